// File: rtl/packed_array_assembler.sv
// -----------------------------------------------------------------------------
// packed_array_assembler
//   Collects ELEM_W-bit elements from a valid/ready stream and assembles them
//   into a packed [OUTER-1:0][INNER-1:0][ELEM_W-1:0] frame. The frame is then
//   offered on a valid/ready output. A frame whose in_last marker is early or
//   missing is dropped, and frame_err pulses for one cycle.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   element present on in_data
//   in_ready   element can be accepted this cycle (!out_valid || out_ready)
//   in_data    element value
//   in_last    final element of a frame
//   out_valid  complete frame held on out_data
//   out_ready  consumer accepts the frame
//   out_data   assembled frame; element [i][j] sits at bits (i*INNER+j)*ELEM_W
//   frame_err  one-cycle pulse after a framing error
//   elem_cnt   number of elements accepted into the current frame
// -----------------------------------------------------------------------------
module packed_array_assembler #(
  parameter int OUTER  = 2,
  parameter int INNER  = 3,
  parameter int ELEM_W = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [ELEM_W-1:0]                        in_data,
  input  logic                                     in_last,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [OUTER-1:0][INNER-1:0][ELEM_W-1:0]  out_data,
  output logic                                     frame_err,
  output logic [$clog2(OUTER*INNER+1)-1:0]         elem_cnt
);

  localparam int N  = OUTER * INNER;
  localparam int CW = $clog2(N + 1);
  localparam int IW = (OUTER > 1) ? $clog2(OUTER) : 1;
  localparam int JW = (INNER > 1) ? $clog2(INNER) : 1;

  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]                             r_state;
  logic [IW-1:0]                          r_i;
  logic [JW-1:0]                          r_j;
  logic [CW-1:0]                          r_cnt;
  logic                                   r_err;
  logic [OUTER-1:0][INNER-1:0][ELEM_W-1:0] r_data;

  logic          w_hold;
  logic          w_accept;
  logic          w_handshake;
  logic [IW-1:0] w_i;
  logic [JW-1:0] w_j;
  logic [CW-1:0] w_cnt;
  logic          w_at_last;

  assign w_hold      = (r_state == S_HOLD);
  assign in_ready    = !w_hold || out_ready;
  assign w_accept    = in_valid && in_ready;
  assign w_handshake = w_hold && out_ready;

  // An accept while holding always coincides with the output handshake, so
  // that element starts a fresh frame at slot [0][0] regardless of r_i/r_j.
  assign w_i   = w_hold ? '0 : r_i;
  assign w_j   = w_hold ? '0 : r_j;
  assign w_cnt = w_hold ? '0 : r_cnt;

  assign w_at_last = (w_i == IW'(OUTER - 1)) && (w_j == JW'(INNER - 1));

  assign out_valid = w_hold;
  assign out_data  = r_data;
  assign frame_err = r_err;
  assign elem_cnt  = r_cnt;

  // Frame assembly, hold/handshake sequencing and framing-error detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FILL;
      r_i     <= '0;
      r_j     <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_err <= 1'b0;
      if (w_accept) begin
        if (in_last && w_at_last) begin
          // Correctly terminated frame: present it next cycle.
          r_data[w_i][w_j] <= in_data;
          r_state          <= S_HOLD;
          r_i              <= '0;
          r_j              <= '0;
          r_cnt            <= CW'(N);
        end else if (in_last || w_at_last) begin
          // Early or missing in_last: drop the partial frame.
          r_data  <= '0;
          r_state <= S_FILL;
          r_i     <= '0;
          r_j     <= '0;
          r_cnt   <= '0;
          r_err   <= 1'b1;
        end else begin
          r_data[w_i][w_j] <= in_data;
          r_state          <= S_FILL;
          r_cnt            <= w_cnt + CW'(1);
          if (w_j == JW'(INNER - 1)) begin
            r_j <= '0;
            r_i <= w_i + IW'(1);
          end else begin
            r_j <= w_j + JW'(1);
            r_i <= w_i;
          end
        end
      end else if (w_handshake) begin
        // Frame consumed with nothing arriving: stale data stays but is hidden.
        r_state <= S_FILL;
        r_cnt   <= '0;
      end
    end
  end

endmodule
